uart_tx_fifo: RTL and testbench

Buffered UART transmitter for the host-facing side of the serial link. Accepts bytes from local logic into a small FIFO and serialises them on tx as 8-N-1 frames, LSB first. Generates its own bit timing directly from the system clock. Pairs with the existing UART receiver so a far-end device receives bursts of bytes without the writer pacing each one.

---
 rtl/uart_tx_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered UART transmitter. Bytes written by local logic are queued in a
//   2**ADDR_W entry FIFO and sent on tx as 8-N-1 frames, LSB first. Bit
//   timing is derived from clk by rounding CLK_FREQ/BAUD to the nearest
//   integer number of clocks per bit.
//
//   Optional build macro UART_TX_PARITY_EN: adds an even-parity bit between
//   the data bits and the stop bit (8-E-1 frames).
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   wr_en     push din when full is low
//   din       byte to transmit
//   full      FIFO holds 2**ADDR_W entries
//   empty     FIFO holds 0 entries
//   count     FIFO occupancy
//   overflow  one-cycle pulse: write attempted while full, byte dropped
//   busy      frame in progress (start through stop bit)
//   tx        serial line, idle high, driven straight from a flop
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_FREQ = 27000000,
    parameter int BAUD     = 9600,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        din,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy,
    output logic              tx
);

    // state    | meaning
    // IDLE     | line high, waiting for a queued byte
    // START    | start bit (low) for DIV clocks
    // DATA     | eight data bits, LSB first, DIV clocks each
    // PARITY   | even-parity bit (UART_TX_PARITY_EN builds only)
    // STOP     | stop bit (high); pops the next byte back-to-back if any

    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_fifo: bit period DIV=%0d clocks is below the minimum of 2", DIV);
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     count_nxt;
    logic [CNT_W-1:0]    baud_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shreg;
    logic [7:0]          head;
    logic                baud_end;
    logic                wr_ok;
    logic                pop;
`ifdef UART_TX_PARITY_EN
    logic                parity_bit;
`endif

    assign head     = mem[rd_ptr];
    assign baud_end = (baud_cnt == CNT_W'(DIV - 1));
    assign wr_ok    = wr_en && !full;
    // A byte leaves the FIFO when idle, or at the very end of a stop bit so
    // the next start bit follows with no idle gap.
    assign pop      = !empty && ((state == IDLE) || (state == STOP && baud_end));

    always_comb begin
        count_nxt = count;
        if (wr_ok && !pop) begin
            count_nxt = count + (ADDR_W + 1)'(1);
        end else if (!wr_ok && pop) begin
            count_nxt = count - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_nxt;
            full     <= (count_nxt == (ADDR_W + 1)'(DEPTH));
            empty    <= (count_nxt == '0);
            overflow <= wr_en && full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (state == IDLE || baud_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg      <= head;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^head;
`endif
                    end
                end
                START: begin
                    if (baud_end) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        if (pop) begin
                            shreg      <= head;
                            tx         <= 1'b0;
                            state      <= START;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^head;
`endif
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int ADDR_W   = 4;
    localparam int DIV      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int LEN      = 11 * DIV;
`else
    localparam int LEN      = 10 * DIV;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [7:0]        din = 8'h00;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              busy;
    logic              tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rst_cnt = 0;
    logic [7:0] exp_q[$];
    int         fall_q[$];

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .busy(busy), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_cnt = rst_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected line level k clocks after the start-bit falling edge.
    function automatic logic exp_bit(input int k, input logic [7:0] b);
        int p;
        p = k / DIV;
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
`ifdef UART_TX_PARITY_EN
        if (p == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // One write spanning a single rising edge; returns on the following negedge.
    task automatic wr(input logic [7:0] b, input bit accept);
        din   = b;
        wr_en = 1'b1;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 1'b0);
    endtask

    // Single frame into an idle block, checked clock by clock.
    task automatic send_single(input logic [7:0] b);
        int bad;
        bad = 0;
        wr(b, 1'b1);
        check("single_empty_after_write", empty, 1'b0);
        check("single_tx_still_idle", tx, 1'b1);
        din = ~b;
        @(negedge clk);
        check("single_empty_after_pop", empty, 1'b1);
        for (int k = 0; k < LEN; k++) begin
            if (tx !== exp_bit(k, b) || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        check("single_waveform_mismatches", bad, 0);
        check("single_busy_end", busy, 1'b0);
        check("single_tx_end", tx, 1'b1);
        wait_drain(50);
    endtask

    // Receiver model: mid-bit sampling, compares against the scoreboard.
    initial begin : monitor
        logic       prev;
        logic [7:0] d;
        logic [7:0] e;
        logic       s0;
        logic       st;
        logic       pb;
        int         r0;
        prev = 1'b1;
        pb   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && prev === 1'b1 && tx === 1'b0) begin
                r0 = rst_cnt;
                fall_q.push_back(cyc);
                repeat (DIV / 2) @(negedge clk);
                s0 = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    d[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                pb = tx;
`endif
                repeat (DIV) @(negedge clk);
                st = tx;
                if (rst_cnt == r0) begin
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected_frame", {24'h0, d}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_start_bit", s0, 1'b0);
                        check("rx_data", d, e);
                        check("rx_stop_bit", st, 1'b1);
`ifdef UART_TX_PARITY_EN
                        check("rx_parity", pb, ^e);
`endif
                    end
                end
            end
            prev = tx;
        end
    end

    initial begin : stim
        int bad;
        int peak;
        logic [7:0] b;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1 || count !== 0 || overflow !== 1'b0) bad++;
        end
        check("idle_50_mismatches", bad, 0);

        // Single frames (0x07 / 0x03 also exercise parity 1 / 0)
        send_single(8'h55);
        send_single(8'h07);
        send_single(8'h03);

        // Burst of three, back-to-back frames
        fall_q.delete();
        wr(8'h01, 1'b1);
        check("burst_count_1", count, 1);
        wr(8'h02, 1'b1);
        check("burst_count_2", count, 1);
        wr(8'h03, 1'b1);
        check("burst_count_3", count, 2);
        peak = 2;
        repeat (20) begin
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
        end
        check("burst_peak", peak, 2);
        wait_drain(400);
        check("burst_frames", fall_q.size(), 3);
        if (fall_q.size() == 3) begin
            check("burst_gap_1", fall_q[1] - fall_q[0], LEN);
            check("burst_gap_2", fall_q[2] - fall_q[1], LEN);
        end

        // Fill to full, then overflow
        for (int i = 0; i < 17; i++) begin
            b = 8'(8'h10 + i * 5);
            wr(b, 1'b1);
        end
        check("fill_full", full, 1'b1);
        check("fill_count", count, 16);
        check("fill_no_overflow", overflow, 1'b0);
        wr(8'hEE, 1'b0);
        check("ovf_pulse", overflow, 1'b1);
        check("ovf_count", count, 16);
        check("ovf_full", full, 1'b1);
        @(negedge clk);
        check("ovf_pulse_end", overflow, 1'b0);
        check("ovf_count_after", count, 16);
        wait_drain(2100);
        check("fill_empty_after", empty, 1'b1);

        // Asynchronous reset mid-frame
        wr(8'hA5, 1'b0);
        wr(8'h3C, 1'b0);
        repeat (24) @(negedge clk);
        check("mid_tx_low_before_reset", tx, 1'b0);
        check("mid_count_before_reset", count, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_tx", tx, 1'b1);
        check("async_busy", busy, 1'b0);
        check("async_empty", empty, 1'b1);
        check("async_count", count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("post_reset_quiet", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
